// File: rtl/unidad_de_control_multiciclo.sv
// Multi-cycle control unit: fetch/decode/execute/memory/writeback/halt FSM
// that latches the instruction, sequences datapath strobes and counts retires.
//
// Ports:
//   Reloj, Reiniciar       clock, synchronous active-high reset
//   Instruccion, MemListo  instruction word and memory ready handshake
//   Cero                   ALU zero flag, used to resolve BEQ
//   Control                one-hot state {DET,ESC,MEM,EJE,DEC,BUS}
//   LoadSelect             {SelDR,LdDR,SelAR,LdAR,SelPC[1:0],LdPC,LdIR,LdCR,WrSel,WrEn}
//   WriteAddress/ReadAddressA/ReadAddressB  Rd/Rf1/Rf2 of latched instruction
//   Fun, MemEscribe        ALU function, memory write request
//   Error, ContadorInstr   sticky illegal-opcode flag, saturating retire count
module unidad_de_control_multiciclo #(
    parameter int ANCHO_INSTR = 16,
    parameter int ANCHO_REG   = 3,
    parameter int ANCHO_OPC   = ANCHO_INSTR - 3*ANCHO_REG,
    parameter int ANCHO_CONT  = 8
) (
    input  logic                   Reloj,
    input  logic                   Reiniciar,
    input  logic [ANCHO_INSTR-1:0] Instruccion,
    input  logic                   MemListo,
    input  logic                   Cero,
    output logic [5:0]             Control,
    output logic [10:0]            LoadSelect,
    output logic [ANCHO_REG-1:0]   WriteAddress,
    output logic [ANCHO_REG-1:0]   ReadAddressA,
    output logic [ANCHO_REG-1:0]   ReadAddressB,
    output logic [3:0]             Fun,
    output logic                   MemEscribe,
    output logic                   Error,
    output logic [ANCHO_CONT-1:0]  ContadorInstr
);

    typedef enum logic [5:0] {
        BUSQUEDA   = 6'b000001,
        DECODIFICA = 6'b000010,
        EJECUTA    = 6'b000100,
        MEMORIA    = 6'b001000,
        ESCRITURA  = 6'b010000,
        DETENIDO   = 6'b100000
    } estado_t;

    localparam logic [ANCHO_OPC-1:0] OPC_LOAD  = ANCHO_OPC'(16);
    localparam logic [ANCHO_OPC-1:0] OPC_STORE = ANCHO_OPC'(17);
    localparam logic [ANCHO_OPC-1:0] OPC_BEQ   = ANCHO_OPC'(18);
    localparam logic [ANCHO_OPC-1:0] OPC_JMP   = ANCHO_OPC'(19);
    localparam logic [ANCHO_OPC-1:0] OPC_HALT  = '1;

    estado_t                estado_q, estado_d;
    logic [ANCHO_INSTR-1:0] instr_q, instr_d;
    logic                   error_q, error_d;
    logic [ANCHO_CONT-1:0]  cont_q, cont_d;
    logic                   retira;

    logic [ANCHO_OPC-1:0] opc;
    logic es_alu, es_load, es_store, es_beq, es_jmp, es_halt;

    assign opc      = instr_q[ANCHO_INSTR-1 -: ANCHO_OPC];
    assign es_alu   = (opc < ANCHO_OPC'(16));
    assign es_load  = (opc == OPC_LOAD);
    assign es_store = (opc == OPC_STORE);
    assign es_beq   = (opc == OPC_BEQ);
    assign es_jmp   = (opc == OPC_JMP);
    assign es_halt  = (opc == OPC_HALT);

    assign WriteAddress = instr_q[3*ANCHO_REG-1 -: ANCHO_REG];
    assign ReadAddressA = instr_q[2*ANCHO_REG-1 -: ANCHO_REG];
    assign ReadAddressB = instr_q[ANCHO_REG-1:0];

    // Memory ops use add for address calc, BEQ compares by subtraction
    assign Fun = es_alu ? opc[3:0] :
                 es_beq ? 4'b0001  : 4'b0000;

    assign Control       = estado_q;
    assign Error         = error_q;
    assign ContadorInstr = cont_q;

    // State register
    always_ff @(posedge Reloj) begin
        if (Reiniciar) begin
            estado_q <= BUSQUEDA;
            instr_q  <= '0;
            error_q  <= 1'b0;
            cont_q   <= '0;
        end else begin
            estado_q <= estado_d;
            instr_q  <= instr_d;
            error_q  <= error_d;
            cont_q   <= cont_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        instr_d  = instr_q;
        error_d  = error_q;
        retira   = 1'b0;
        unique case (estado_q)
            BUSQUEDA: begin
                if (MemListo) begin
                    instr_d  = Instruccion;
                    estado_d = DECODIFICA;
                end
            end
            DECODIFICA: begin
                if (es_jmp) begin
                    estado_d = BUSQUEDA;
                    retira   = 1'b1;
                end else if (es_halt) begin
                    estado_d = DETENIDO;
                    retira   = 1'b1;
                end else if (es_alu || es_load || es_store || es_beq) begin
                    estado_d = EJECUTA;
                end else begin
                    error_d  = 1'b1;
                    estado_d = DETENIDO;
                end
            end
            EJECUTA: begin
                if (es_beq) begin
                    estado_d = BUSQUEDA;
                    retira   = 1'b1;
                end else if (es_load || es_store) begin
                    estado_d = MEMORIA;
                end else begin
                    estado_d = ESCRITURA;
                end
            end
            MEMORIA: begin
                if (MemListo) begin
                    if (es_store) begin
                        estado_d = BUSQUEDA;
                        retira   = 1'b1;
                    end else begin
                        estado_d = ESCRITURA;
                    end
                end
            end
            ESCRITURA: begin
                estado_d = BUSQUEDA;
                retira   = 1'b1;
            end
            DETENIDO: begin
                estado_d = DETENIDO;
            end
            default: begin
                estado_d = BUSQUEDA;
            end
        endcase
    end

    // Saturating retire counter
    always_comb begin
        cont_d = cont_q;
        if (retira && (cont_q != '1)) begin
            cont_d = cont_q + ANCHO_CONT'(1);
        end
    end

    // Strobe decode
    logic       sel_dr, ld_dr, sel_ar, ld_ar;
    logic [1:0] sel_pc;
    logic       ld_pc, ld_ir, ld_cr, wr_sel, wr_en, mem_we;

    always_comb begin
        sel_dr = 1'b0;
        ld_dr  = 1'b0;
        sel_ar = 1'b0;
        ld_ar  = 1'b0;
        sel_pc = 2'b00;
        ld_pc  = 1'b0;
        ld_ir  = 1'b0;
        ld_cr  = 1'b0;
        wr_sel = 1'b0;
        wr_en  = 1'b0;
        mem_we = 1'b0;
        unique case (estado_q)
            BUSQUEDA: begin
                if (MemListo) begin
                    ld_ir = 1'b1;
                    ld_pc = 1'b1;
                end
            end
            DECODIFICA: begin
                if (es_jmp) begin
                    ld_pc  = 1'b1;
                    sel_pc = 2'b10;
                end
            end
            EJECUTA: begin
                if (es_beq) begin
                    if (Cero) begin
                        ld_pc  = 1'b1;
                        sel_pc = 2'b01;
                    end
                end else if (es_load || es_store) begin
                    ld_ar = 1'b1;
                end else begin
                    ld_dr = 1'b1;
                    ld_cr = 1'b1;
                end
            end
            MEMORIA: begin
                if (es_store) begin
                    mem_we = 1'b1;
                end else if (MemListo) begin
                    ld_dr  = 1'b1;
                    sel_dr = 1'b1;
                end
            end
            ESCRITURA: begin
                wr_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign LoadSelect = {sel_dr, ld_dr, sel_ar, ld_ar, sel_pc,
                         ld_pc, ld_ir, ld_cr, wr_sel, wr_en};
    assign MemEscribe = mem_we;

endmodule

// File: tb/tb_unidad_de_control_multiciclo.sv
// Directed bench for the multi-cycle control unit.
// Each scenario task checks its own outputs against hand-computed values.
module tb_unidad_de_control_multiciclo;

    logic        Reloj;
    logic        Reiniciar;
    logic [15:0] Instruccion;
    logic        MemListo;
    logic        Cero;
    logic [5:0]  Control;
    logic [10:0] LoadSelect;
    logic [2:0]  WriteAddress;
    logic [2:0]  ReadAddressA;
    logic [2:0]  ReadAddressB;
    logic [3:0]  Fun;
    logic        MemEscribe;
    logic        Error;
    logic [7:0]  ContadorInstr;

    int vectors = 0;
    int miscompares = 0;

    unidad_de_control_multiciclo dut (
        .Reloj        (Reloj),
        .Reiniciar    (Reiniciar),
        .Instruccion  (Instruccion),
        .MemListo     (MemListo),
        .Cero         (Cero),
        .Control      (Control),
        .LoadSelect   (LoadSelect),
        .WriteAddress (WriteAddress),
        .ReadAddressA (ReadAddressA),
        .ReadAddressB (ReadAddressB),
        .Fun          (Fun),
        .MemEscribe   (MemEscribe),
        .Error        (Error),
        .ContadorInstr(ContadorInstr)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    task automatic tick();
        @(posedge Reloj);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        Reiniciar = 1'b1;
        MemListo = 1'b0;
        Cero = 1'b0;
        Instruccion = '0;
        tick();
        tick();
        Reiniciar = 1'b0;
        settle();
        vectors++;
        if (Control !== 6'h01) begin
            miscompares++;
            $display("FAIL rst_ctl got %h exp %h", Control, 6'h01);
        end
        vectors++;
        if (LoadSelect !== 11'h000 || MemEscribe !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_strobes got %h/%b exp 000/0", LoadSelect, MemEscribe);
        end
        vectors++;
        if (Error !== 1'b0 || ContadorInstr !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_err_cnt got %b/%h exp 0/00", Error, ContadorInstr);
        end
        vectors++;
        if ({WriteAddress, ReadAddressA, ReadAddressB, Fun} !== 13'h0) begin
            miscompares++;
            $display("FAIL rst_fields got %h %h %h %h exp 0", WriteAddress,
                     ReadAddressA, ReadAddressB, Fun);
        end
    endtask

    task automatic test_alu();
        Instruccion = {7'h03, 3'd0, 3'd1, 3'd2};
        MemListo = 1'b1;
        settle();
        vectors++;
        if (Control !== 6'h01 || LoadSelect !== 11'h018) begin
            miscompares++;
            $display("FAIL alu_fetch got %h/%h exp 01/018", Control, LoadSelect);
        end
        tick();
        settle();
        vectors++;
        if (Control !== 6'h02 || LoadSelect !== 11'h000) begin
            miscompares++;
            $display("FAIL alu_dec got %h/%h exp 02/000", Control, LoadSelect);
        end
        vectors++;
        if (ReadAddressA !== 3'd1 || ReadAddressB !== 3'd2) begin
            miscompares++;
            $display("FAIL alu_rdaddr got %0d/%0d exp 1/2", ReadAddressA, ReadAddressB);
        end
        tick();
        settle();
        vectors++;
        if (Control !== 6'h04 || LoadSelect !== 11'h204 || Fun !== 4'h3) begin
            miscompares++;
            $display("FAIL alu_exe got %h/%h/%h exp 04/204/3", Control, LoadSelect, Fun);
        end
        tick();
        settle();
        vectors++;
        if (Control !== 6'h10 || LoadSelect !== 11'h001 || WriteAddress !== 3'd0) begin
            miscompares++;
            $display("FAIL alu_wb got %h/%h/%0d exp 10/001/0", Control, LoadSelect,
                     WriteAddress);
        end
        tick();
        settle();
        vectors++;
        if (Control !== 6'h01 || ContadorInstr !== 8'd1) begin
            miscompares++;
            $display("FAIL alu_retire got %h/%0d exp 01/1", Control, ContadorInstr);
        end
    endtask

    task automatic test_load();
        Instruccion = {7'h10, 3'd3, 3'd4, 3'd5};
        MemListo = 1'b1;
        tick();
        tick();
        settle();
        vectors++;
        if (Control !== 6'h04 || LoadSelect !== 11'h080 || Fun !== 4'h0) begin
            miscompares++;
            $display("FAIL ld_exe got %h/%h/%h exp 04/080/0", Control, LoadSelect, Fun);
        end
        MemListo = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++;
            if (Control !== 6'h08 || LoadSelect !== 11'h000) begin
                miscompares++;
                $display("FAIL ld_wait%0d got %h/%h exp 08/000", i, Control, LoadSelect);
            end
            tick();
        end
        MemListo = 1'b1;
        settle();
        vectors++;
        if (Control !== 6'h08 || LoadSelect !== 11'h600) begin
            miscompares++;
            $display("FAIL ld_ready got %h/%h exp 08/600", Control, LoadSelect);
        end
        tick();
        settle();
        vectors++;
        if (Control !== 6'h10 || LoadSelect !== 11'h001 || WriteAddress !== 3'd3) begin
            miscompares++;
            $display("FAIL ld_wb got %h/%h/%0d exp 10/001/3", Control, LoadSelect,
                     WriteAddress);
        end
        tick();
        settle();
        vectors++;
        if (Control !== 6'h01 || ContadorInstr !== 8'd2) begin
            miscompares++;
            $display("FAIL ld_retire got %h/%0d exp 01/2", Control, ContadorInstr);
        end
    endtask

    task automatic test_store();
        int we;
        we = 0;
        Instruccion = {7'h11, 3'd1, 3'd2, 3'd3};
        MemListo = 1'b1;
        tick();
        tick();
        settle();
        vectors++;
        if (Control !== 6'h04 || LoadSelect !== 11'h080 || MemEscribe !== 1'b0) begin
            miscompares++;
            $display("FAIL st_exe got %h/%h/%b exp 04/080/0", Control, LoadSelect,
                     MemEscribe);
        end
        MemListo = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            settle();
            if (MemEscribe === 1'b1) we++;
            vectors++;
            if (Control !== 6'h08 || LoadSelect !== 11'h000) begin
                miscompares++;
                $display("FAIL st_wait%0d got %h/%h exp 08/000", i, Control, LoadSelect);
            end
            tick();
        end
        MemListo = 1'b1;
        settle();
        if (MemEscribe === 1'b1) we++;
        vectors++;
        if (Control !== 6'h08 || LoadSelect !== 11'h000) begin
            miscompares++;
            $display("FAIL st_ready got %h/%h exp 08/000", Control, LoadSelect);
        end
        tick();
        settle();
        vectors++;
        if (we !== 3) begin
            miscompares++;
            $display("FAIL st_we_cycles got %0d exp 3", we);
        end
        vectors++;
        if (Control !== 6'h01 || ContadorInstr !== 8'd3 || MemEscribe !== 1'b0) begin
            miscompares++;
            $display("FAIL st_retire got %h/%0d/%b exp 01/3/0", Control, ContadorInstr,
                     MemEscribe);
        end
    endtask

    task automatic test_beq();
        Instruccion = {7'h12, 3'd0, 3'd1, 3'd2};
        MemListo = 1'b1;
        Cero = 1'b1;
        tick();
        tick();
        settle();
        vectors++;
        if (Control !== 6'h04 || LoadSelect !== 11'h030 || Fun !== 4'h1) begin
            miscompares++;
            $display("FAIL beq_taken got %h/%h/%h exp 04/030/1", Control, LoadSelect, Fun);
        end
        tick();
        settle();
        vectors++;
        if (Control !== 6'h01) begin
            miscompares++;
            $display("FAIL beq_taken_ret got %h exp 01", Control);
        end
        Cero = 1'b0;
        tick();
        tick();
        settle();
        vectors++;
        if (Control !== 6'h04 || LoadSelect !== 11'h000) begin
            miscompares++;
            $display("FAIL beq_not got %h/%h exp 04/000", Control, LoadSelect);
        end
        tick();
        settle();
        vectors++;
        if (Control !== 6'h01 || ContadorInstr !== 8'd5) begin
            miscompares++;
            $display("FAIL beq_retire got %h/%0d exp 01/5", Control, ContadorInstr);
        end
    endtask

    task automatic test_jmp();
        Instruccion = {7'h13, 9'd0};
        MemListo = 1'b1;
        tick();
        settle();
        vectors++;
        if (Control !== 6'h02 || LoadSelect !== 11'h050) begin
            miscompares++;
            $display("FAIL jmp_dec got %h/%h exp 02/050", Control, LoadSelect);
        end
        tick();
        settle();
        vectors++;
        if (Control !== 6'h01 || ContadorInstr !== 8'd6) begin
            miscompares++;
            $display("FAIL jmp_retire got %h/%0d exp 01/6", Control, ContadorInstr);
        end
    endtask

    task automatic test_reset_mid();
        Instruccion = {7'h10, 3'd6, 3'd0, 3'd0};
        MemListo = 1'b1;
        tick();
        tick();
        MemListo = 1'b0;
        tick();
        tick();
        settle();
        vectors++;
        if (Control !== 6'h08) begin
            miscompares++;
            $display("FAIL rmid_mem got %h exp 08", Control);
        end
        Reiniciar = 1'b1;
        tick();
        Reiniciar = 1'b0;
        settle();
        vectors++;
        if (Control !== 6'h01 || ContadorInstr !== 8'd0 || WriteAddress !== 3'd0) begin
            miscompares++;
            $display("FAIL rmid_after got %h/%0d/%0d exp 01/0/0", Control,
                     ContadorInstr, WriteAddress);
        end
        vectors++;
        if (LoadSelect !== 11'h000) begin
            miscompares++;
            $display("FAIL rmid_strobes got %h exp 000", LoadSelect);
        end
        MemListo = 1'b1;
    endtask

    task automatic test_halt();
        Instruccion = {7'h7F, 9'd0};
        MemListo = 1'b1;
        tick();
        tick();
        settle();
        vectors++;
        if (Control !== 6'h20 || ContadorInstr !== 8'd1 || Error !== 1'b0) begin
            miscompares++;
            $display("FAIL halt got %h/%0d/%b exp 20/1/0", Control, ContadorInstr, Error);
        end
        tick();
        tick();
        settle();
        vectors++;
        if (Control !== 6'h20 || LoadSelect !== 11'h000) begin
            miscompares++;
            $display("FAIL halt_hold got %h/%h exp 20/000", Control, LoadSelect);
        end
        Reiniciar = 1'b1;
        tick();
        Reiniciar = 1'b0;
    endtask

    task automatic test_illegal();
        Instruccion = {7'h2A, 9'd0};
        MemListo = 1'b1;
        tick();
        settle();
        vectors++;
        if (Control !== 6'h02 || Error !== 1'b0) begin
            miscompares++;
            $display("FAIL ill_dec got %h/%b exp 02/0", Control, Error);
        end
        tick();
        settle();
        vectors++;
        if (Control !== 6'h20 || Error !== 1'b1 || ContadorInstr !== 8'd0) begin
            miscompares++;
            $display("FAIL ill_stop got %h/%b/%0d exp 20/1/0", Control, Error,
                     ContadorInstr);
        end
        repeat (5) tick();
        settle();
        vectors++;
        if (Control !== 6'h20 || Error !== 1'b1 || LoadSelect !== 11'h000) begin
            miscompares++;
            $display("FAIL ill_sticky got %h/%b/%h exp 20/1/000", Control, Error,
                     LoadSelect);
        end
        Reiniciar = 1'b1;
        tick();
        Reiniciar = 1'b0;
        MemListo = 1'b0;
        settle();
        vectors++;
        if (Control !== 6'h01 || Error !== 1'b0 || LoadSelect !== 11'h000) begin
            miscompares++;
            $display("FAIL ill_clear got %h/%b/%h exp 01/0/000", Control, Error,
                     LoadSelect);
        end
        MemListo = 1'b1;
    endtask

    task automatic test_back_to_back();
        Instruccion = {7'h13, 9'd0};
        MemListo = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            tick();
            if (i == 254) begin
                vectors++;
                if (ContadorInstr !== 8'hFE) begin
                    miscompares++;
                    $display("FAIL b2b_254 got %h exp fe", ContadorInstr);
                end
            end
            if (i == 255 || i == 300) begin
                vectors++;
                if (ContadorInstr !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL b2b_sat%0d got %h exp ff", i, ContadorInstr);
                end
            end
        end
        settle();
        vectors++;
        if (Control !== 6'h01) begin
            miscompares++;
            $display("FAIL b2b_ctl got %h exp 01", Control);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_beq();
        test_jmp();
        test_reset_mid();
        test_halt();
        test_illegal();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
